// File: rtl/multi_shifter.sv
// ============================================================================
// Module      : multi_shifter
// Description : Multi-cycle shifter, up to STEP bit positions per clock, with
//               logical, arithmetic and rotate modes plus a carry-out bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_shifter #(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             write_pulse_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] shift_amount_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             busy_o,
    output logic             ready_pulse_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] data_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0]       C_MODE_LSL = 3'b000;
    localparam logic [2:0]       C_MODE_LSR = 3'b001;
    localparam logic [2:0]       C_MODE_ASR = 3'b010;
    localparam logic [2:0]       C_MODE_ROL = 3'b011;
    localparam logic [2:0]       C_MODE_ROR = 3'b100;
    localparam logic [AMT_W-1:0] C_STEP     = AMT_W'(STEP);
    localparam logic [AMT_W:0]   C_WIDTH    = (AMT_W+1)'(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_remaining;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic             r_ready;

    logic             w_last;
    logic [AMT_W-1:0] w_k;
    logic [AMT_W:0]   w_rk;
    logic [WIDTH:0]   w_left_ext;
    logic [WIDTH:0]   w_right_ext;
    logic [WIDTH-1:0] w_asr;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;
    logic             w_pass_mode;

    assign w_pass_mode = (mode_i > C_MODE_ROR);
    assign w_last      = (r_remaining <= C_STEP);
    assign w_k         = w_last ? r_remaining : C_STEP;
    assign w_rk        = C_WIDTH - {1'b0, w_k};

    // The extra bit on each side catches the last bit shifted out, which is
    // the carry for both the plain shifts and the rotates in that direction.
    assign w_left_ext  = {1'b0, r_data} << w_k;
    assign w_right_ext = {r_data, 1'b0} >> w_k;
    assign w_asr       = WIDTH'($signed(r_data) >>> w_k);

    always_comb begin
        w_step_data  = r_data;
        w_step_carry = 1'b0;
        case (r_mode)
            C_MODE_LSL: begin
                w_step_data  = w_left_ext[WIDTH-1:0];
                w_step_carry = w_left_ext[WIDTH];
            end
            C_MODE_LSR: begin
                w_step_data  = w_right_ext[WIDTH:1];
                w_step_carry = w_right_ext[0];
            end
            C_MODE_ASR: begin
                w_step_data  = w_asr;
                w_step_carry = w_right_ext[0];
            end
            C_MODE_ROL: begin
                w_step_data  = w_left_ext[WIDTH-1:0] | (r_data >> w_rk);
                w_step_carry = w_left_ext[WIDTH];
            end
            C_MODE_ROR: begin
                w_step_data  = w_right_ext[WIDTH:1] | (r_data << w_rk);
                w_step_carry = w_right_ext[0];
            end
            default: begin
                w_step_data  = r_data;
                w_step_carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (write_pulse_i) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)        w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_mode      <= 3'b000;
            r_remaining <= '0;
            r_data      <= '0;
            r_carry     <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (r_state == S_IDLE) begin
                if (write_pulse_i) begin
                    r_data      <= data_i;
                    r_mode      <= mode_i;
                    r_remaining <= w_pass_mode ? '0 : shift_amount_i;
                    r_carry     <= 1'b0;
                end
            end else begin
                r_data  <= w_step_data;
                r_carry <= w_step_carry;
                if (w_last) begin
                    r_remaining <= '0;
                    r_ready     <= 1'b1;
                end else begin
                    r_remaining <= r_remaining - C_STEP;
                end
            end
        end
    end

    assign busy_o        = (r_state == S_SHIFT);
    assign ready_pulse_o = r_ready;
    assign carry_o       = r_carry;
    assign data_o        = r_data;

endmodule

`default_nettype wire

// File: tb/tb_multi_shifter.sv
// ============================================================================
// Module      : tb_multi_shifter
// Description : Directed self-checking bench for multi_shifter (16-bit, step 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_shifter;

    localparam int WIDTH = 16;
    localparam int STEP  = 4;
    localparam int AMT_W = 4;

    logic             clk;
    logic             rst;
    logic             write_pulse;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             ready;
    logic             carry;
    logic [WIDTH-1:0] data_out;

    int n_checks = 0;
    int n_fails  = 0;

    multi_shifter #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_dut (
        .clk_i          (clk),
        .reset_i        (rst),
        .write_pulse_i  (write_pulse),
        .mode_i         (mode),
        .shift_amount_i (amount),
        .data_i         (data_in),
        .busy_o         (busy),
        .ready_pulse_o  (ready),
        .carry_o        (carry),
        .data_o         (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepting edge; inputs are then scrambled to prove they were latched.
    task automatic start_op(input logic [2:0] m, input logic [AMT_W-1:0] a,
                            input logic [WIDTH-1:0] d);
        write_pulse = 1'b1;
        mode        = m;
        amount      = a;
        data_in     = d;
        tick();
        write_pulse = 1'b0;
        mode        = ~m;
        amount      = ~a;
        data_in     = ~d;
    endtask

    task automatic wait_ready(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!ready && edges < 40) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input logic [AMT_W-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp_d,
                          input logic exp_c, input int exp_edges);
        int edges;
        int busy_cycles;
        start_op(m, a, d);
        wait_ready(edges, busy_cycles);
        chk({tag, "_edges"}, 32'(edges), 32'(exp_edges));
        chk({tag, "_busycyc"}, 32'(busy_cycles), 32'(exp_edges));
        chk({tag, "_busy_rdy"}, 32'(busy), 32'd0);
        chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
        chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    endtask

    task automatic check_hold(input string tag, input logic [WIDTH-1:0] exp_d, input logic exp_c);
        tick();
        chk({tag, "_rdy_drop"}, 32'(ready), 32'd0);
        chk({tag, "_hold_d"}, 32'(data_out), 32'(exp_d));
        chk({tag, "_hold_c"}, 32'(carry), 32'(exp_c));
    endtask

    initial begin
        int edges;
        int busy_cycles;
        int ready_seen;

        rst         = 1'b1;
        write_pulse = 1'b0;
        mode        = 3'b000;
        amount      = '0;
        data_in     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_ready", 32'(ready),    32'd0);
        chk("rst_carry", 32'(carry),    32'd0);
        chk("rst_data",  32'(data_out), 32'd0);

        // LSL 0x00F1 by 5: steps of 4 then 1
        run_op("lsl5", 3'b000, 4'd5, 16'h00F1, 16'h1E20, 1'b0, 2);
        check_hold("lsl5", 16'h1E20, 1'b0);

        // ASR 0x8001 by 15: steps 4,4,4,3
        run_op("asr15", 3'b010, 4'd15, 16'h8001, 16'hFFFF, 1'b0, 4);
        check_hold("asr15", 16'hFFFF, 1'b0);

        run_op("ror8", 3'b100, 4'd8, 16'h1234, 16'h3412, 1'b0, 2);
        tick();
        run_op("rol1", 3'b011, 4'd1, 16'h8000, 16'h0001, 1'b1, 1);
        tick();

        // Zero amount and pass-through each take a single shift edge
        run_op("lsr0", 3'b001, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1);
        tick();
        run_op("pass", 3'b110, 4'd7, 16'hBEEF, 16'hBEEF, 1'b0, 1);
        tick();

        // Extra rotate/shift patterns with a set carry
        run_op("ror1", 3'b100, 4'd1, 16'h0001, 16'h8000, 1'b1, 1);
        tick();
        run_op("asr6", 3'b010, 4'd6, 16'h7F40, 16'h01FD, 1'b0, 2);
        tick();

        // Write while busy must be ignored
        start_op(3'b001, 4'd12, 16'hFFFF);
        tick();
        write_pulse = 1'b1;
        mode        = 3'b000;
        amount      = 4'd1;
        data_in     = 16'h0001;
        tick();
        write_pulse = 1'b0;
        wait_ready(edges, busy_cycles);
        chk("busywr_edges", 32'(edges + 2), 32'd3);
        chk("busywr_data",  32'(data_out), 32'h000F);
        chk("busywr_carry", 32'(carry),    32'd1);

        // Back-to-back write in the ready cycle
        run_op("b2b", 3'b000, 4'd4, 16'h0001, 16'h0010, 1'b0, 1);
        check_hold("b2b", 16'h0010, 1'b0);

        // Reset after two shift edges aborts the ROL
        start_op(3'b011, 4'd13, 16'hA5A5);
        tick();
        tick();
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",  32'(busy),     32'd0);
        chk("abort_ready", 32'(ready),    32'd0);
        chk("abort_carry", 32'(carry),    32'd0);
        chk("abort_data",  32'(data_out), 32'd0);
        ready_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ready || busy) ready_seen++;
        end
        chk("abort_no_ready", 32'(ready_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
